// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: control-bundle bit map, opcodes, bubble encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

  // Control bundle bit positions
  localparam int REGWRITE = 0;
  localparam int MEMTOREG = 1;
  localparam int MEMREAD  = 2;
  localparam int MEMWRITE = 3;
  localparam int BRANCH   = 4;
  localparam int ALUSRC   = 5;
  localparam int REGDST   = 6;
  localparam int ALUOP_LO = 7;
  localparam int ALUOP_HI = 8;
  localparam int JUMP     = 9;

  localparam int CTRL_BITS = 10;

  // Opcodes of interest to the decode/hazard logic.
  // A load is recognised downstream through the MEMREAD control bit, which the
  // decoder raises for OP_LW.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // A bubble carries no side effects: every control bit cleared.
  localparam logic [CTRL_BITS-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: EX holds a load whose destination is read by the instruction in ID.
// Latency: purely combinational.
// Backpressure: none; the result drives the stall decision in id_ex_stage.
module load_use_detect (
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_load_use
);

  logic w_dst_nonzero;
  logic w_match;

  // $0 is hardwired, so a load into it never creates a dependency.
  assign w_dst_nonzero = (i_ex_rt != 5'd0);
  assign w_match       = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
  assign o_load_use    = i_ex_memread && w_dst_nonzero && w_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and WB->ID bypass.
// Latency: one cycle from ID inputs to ID_EX_* outputs; pc_write/if_id_write are combinational.
// Backpressure: hold freezes everything; load-use deasserts pc_write/if_id_write for one cycle.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic [5:0]        IF_ID_opcode,
  input  logic [4:0]        IF_ID_rs,
  input  logic [4:0]        IF_ID_rt,
  input  logic [4:0]        IF_ID_rd,
  input  logic [4:0]        IF_ID_shamt,
  input  logic [5:0]        IF_ID_funct,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic [5:0]        ID_EX_opcode,
  output logic [4:0]        ID_EX_rs,
  output logic [4:0]        ID_EX_rt,
  output logic [4:0]        ID_EX_rd,
  output logic [4:0]        ID_EX_shamt,
  output logic [5:0]        ID_EX_funct,
  output logic [DATA_W-1:0] ID_EX_rs_data,
  output logic [DATA_W-1:0] ID_EX_rt_data,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic [DATA_W-1:0] ID_EX_pc4,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]        r_opcode;
  logic [4:0]        r_rs, r_rt, r_rd, r_shamt;
  logic [5:0]        r_funct;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm, r_pc4;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_load_use;
  logic              w_bypass_rs, w_bypass_rt;
  logic [DATA_W-1:0] w_rs_data, w_rt_data;
  logic              w_front_write;

  load_use_detect u_load_use_detect (
    .i_ex_memread (r_ctrl[MEMREAD]),
    .i_ex_rt      (r_rt),
    .i_id_rs      (IF_ID_rs),
    .i_id_rt      (IF_ID_rt),
    .o_load_use   (w_load_use)
  );

  // A register written back this cycle is not yet visible in the RF read data,
  // so take the WB value directly; $0 writes are ignored.
  assign w_bypass_rs = wb_reg_write && (wb_dst != 5'd0) && (wb_dst == IF_ID_rs);
  assign w_bypass_rt = wb_reg_write && (wb_dst != 5'd0) && (wb_dst == IF_ID_rt);
  assign w_rs_data   = w_bypass_rs ? wb_data : rf_rdata1;
  assign w_rt_data   = w_bypass_rt ? wb_data : rf_rdata2;

  // Front-end write enable: held on hold or on an unflushed load-use, open during reset.
  always_comb begin
    w_front_write = 1'b1;
    if (rst)             w_front_write = 1'b1;
    else if (hold)       w_front_write = 1'b0;
    else if (flush)      w_front_write = 1'b1;
    else if (w_load_use) w_front_write = 1'b0;
  end

  assign pc_write    = w_front_write;
  assign if_id_write = w_front_write;

  // Pipeline register: reset > hold > (flush | load-use bubble) > normal capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_shamt   <= '0;
      r_funct   <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_pc4     <= '0;
      r_ctrl    <= CTRL_W'(BUBBLE_CTRL);
    end else if (hold) begin
      r_opcode  <= r_opcode;
    end else if (flush || w_load_use) begin
      r_opcode  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_shamt   <= '0;
      r_funct   <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_pc4     <= '0;
      r_ctrl    <= CTRL_W'(BUBBLE_CTRL);
    end else begin
      r_opcode  <= IF_ID_opcode;
      r_rs      <= IF_ID_rs;
      r_rt      <= IF_ID_rt;
      r_rd      <= IF_ID_rd;
      r_shamt   <= IF_ID_shamt;
      r_funct   <= IF_ID_funct;
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_imm     <= id_imm;
      r_pc4     <= id_pc4;
      r_ctrl    <= id_ctrl;
    end
  end

  // Saturating count of load-use bubbles; a flush in the same cycle is not a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!hold && !flush && w_load_use && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign ID_EX_opcode  = r_opcode;
  assign ID_EX_rs      = r_rs;
  assign ID_EX_rt      = r_rt;
  assign ID_EX_rd      = r_rd;
  assign ID_EX_shamt   = r_shamt;
  assign ID_EX_funct   = r_funct;
  assign ID_EX_rs_data = r_rs_data;
  assign ID_EX_rt_data = r_rt_data;
  assign ID_EX_imm     = r_imm;
  assign ID_EX_pc4     = r_pc4;
  assign ID_EX_ctrl    = r_ctrl;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic
// against a behavioural model of the stage.
// Counter width is shrunk so saturation is reachable in a short run.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int CW = 10;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, hold, flush;
  logic [5:0]    IF_ID_opcode, IF_ID_funct;
  logic [4:0]    IF_ID_rs, IF_ID_rt, IF_ID_rd, IF_ID_shamt;
  logic [DW-1:0] id_imm, id_pc4, rf_rdata1, rf_rdata2, wb_data;
  logic [CW-1:0] id_ctrl;
  logic          wb_reg_write;
  logic [4:0]    wb_dst;

  logic [5:0]    ID_EX_opcode, ID_EX_funct;
  logic [4:0]    ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_shamt;
  logic [DW-1:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc4;
  logic [CW-1:0] ID_EX_ctrl;
  logic          pc_write, if_id_write;
  logic [NW-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .IF_ID_opcode(IF_ID_opcode), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .IF_ID_rd(IF_ID_rd), .IF_ID_shamt(IF_ID_shamt), .IF_ID_funct(IF_ID_funct),
    .id_imm(id_imm), .id_pc4(id_pc4), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
    .ID_EX_opcode(ID_EX_opcode), .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt),
    .ID_EX_rd(ID_EX_rd), .ID_EX_shamt(ID_EX_shamt), .ID_EX_funct(ID_EX_funct),
    .ID_EX_rs_data(ID_EX_rs_data), .ID_EX_rt_data(ID_EX_rt_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_pc4(ID_EX_pc4), .ID_EX_ctrl(ID_EX_ctrl),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_cnt(stall_cnt)
  );

  // Model of what sits in EX: one record per stage slot.
  typedef struct {
    logic [5:0]    op;
    logic [4:0]    rs, rt, rd, sh;
    logic [5:0]    fn;
    logic [DW-1:0] rsd, rtd, imm, pc4;
    logic [CW-1:0] ctrl;
  } ex_slot_t;

  ex_slot_t m_ex;
  int       m_cnt;
  logic     m_front;
  int       n_chk  = 0;
  int       n_pass = 0;

  localparam logic [CW-1:0] C_LW  = 10'h027; // RegWrite|MemToReg|MemRead|ALUSrc
  localparam logic [CW-1:0] C_ADD = 10'h141; // RegWrite|RegDst|ALUOp=10

  function automatic ex_slot_t empty_slot();
    ex_slot_t s;
    s.op = 0; s.rs = 0; s.rt = 0; s.rd = 0; s.sh = 0; s.fn = 0;
    s.rsd = 0; s.rtd = 0; s.imm = 0; s.pc4 = 0; s.ctrl = 0;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: check front-end enables before the edge, advance the model, check EX after it.
  // Entered just after a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    logic     dep;
    ex_slot_t nxt;
    #1;
    dep = m_ex.ctrl[MEMREAD] && (m_ex.rt != 0) && (m_ex.rt == IF_ID_rs || m_ex.rt == IF_ID_rt);
    if (rst)        m_front = 1'b1;
    else if (hold)  m_front = 1'b0;
    else if (flush) m_front = 1'b1;
    else            m_front = !dep;
    check("pc_write", 64'(pc_write), 64'(m_front));
    check("if_id_write", 64'(if_id_write), 64'(m_front));
    nxt = m_ex;
    if (rst) begin
      nxt = empty_slot();
      m_cnt = 0;
    end else if (!hold) begin
      if (flush || dep) begin
        nxt = empty_slot();
        if (!flush && m_cnt < (1 << NW) - 1) m_cnt = m_cnt + 1;
      end else begin
        nxt.op = IF_ID_opcode; nxt.rs = IF_ID_rs; nxt.rt = IF_ID_rt; nxt.rd = IF_ID_rd;
        nxt.sh = IF_ID_shamt; nxt.fn = IF_ID_funct; nxt.imm = id_imm; nxt.pc4 = id_pc4;
        nxt.ctrl = id_ctrl;
        nxt.rsd = (wb_reg_write && wb_dst != 0 && wb_dst == IF_ID_rs) ? wb_data : rf_rdata1;
        nxt.rtd = (wb_reg_write && wb_dst != 0 && wb_dst == IF_ID_rt) ? wb_data : rf_rdata2;
      end
    end
    @(posedge clk);
    #1;
    m_ex = nxt;
    check("opcode", 64'(ID_EX_opcode), 64'(m_ex.op));
    check("rs", 64'(ID_EX_rs), 64'(m_ex.rs));
    check("rt", 64'(ID_EX_rt), 64'(m_ex.rt));
    check("rd", 64'(ID_EX_rd), 64'(m_ex.rd));
    check("shamt", 64'(ID_EX_shamt), 64'(m_ex.sh));
    check("funct", 64'(ID_EX_funct), 64'(m_ex.fn));
    check("rs_data", 64'(ID_EX_rs_data), 64'(m_ex.rsd));
    check("rt_data", 64'(ID_EX_rt_data), 64'(m_ex.rtd));
    check("imm", 64'(ID_EX_imm), 64'(m_ex.imm));
    check("pc4", 64'(ID_EX_pc4), 64'(m_ex.pc4));
    check("ctrl", 64'(ID_EX_ctrl), 64'(m_ex.ctrl));
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [CW-1:0] ctrl);
    IF_ID_opcode = op; IF_ID_rs = rs; IF_ID_rt = rt; IF_ID_rd = rd; id_ctrl = ctrl;
    IF_ID_shamt = 5'd3; IF_ID_funct = 6'h20;
    id_imm = 32'h10 + 32'(rd); id_pc4 = 32'h400 + 32'(rs);
    rf_rdata1 = 32'h1000 + 32'(rs); rf_rdata2 = 32'h2000 + 32'(rt);
  endtask

  initial begin
    m_ex = empty_slot();
    m_cnt = 0;
    m_front = 1'b1;
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    wb_reg_write = 1'b0; wb_dst = 0; wb_data = 0;
    set_id(OP_RTYPE, 0, 0, 0, '0);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Some traffic, then reset mid-stream for two cycles.
    set_id(OP_LW, 2, 8, 0, C_LW); step();
    set_id(OP_RTYPE, 8, 10, 9, C_ADD);
    rst = 1'b1; #1;
    check("rst_pc_write", 64'(pc_write), 64'd1);
    step(); step();
    check("rst_ctrl", 64'(ID_EX_ctrl), 64'd0);
    check("rst_rt", 64'(ID_EX_rt), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // lw $8 in EX, add $9,$8,$10 in ID: one stall, then add loads.
    set_id(OP_LW, 2, 8, 0, C_LW); step();
    set_id(OP_RTYPE, 8, 10, 9, C_ADD); #1;
    check("lu_pc_write", 64'(pc_write), 64'd0);
    check("lu_if_id_write", 64'(if_id_write), 64'd0);
    step();
    check("lu_bubble_ctrl", 64'(ID_EX_ctrl), 64'd0);
    check("lu_bubble_rd", 64'(ID_EX_rd), 64'd0);
    check("lu_cnt", 64'(stall_cnt), 64'd1);
    #1;
    check("lu_release", 64'(pc_write), 64'd1);
    step();
    check("lu_add_rs", 64'(ID_EX_rs), 64'd8);
    check("lu_add_rd", 64'(ID_EX_rd), 64'd9);
    check("lu_cnt_after", 64'(stall_cnt), 64'd1);

    // No-stall cases: load into $0, and a reader of an unrelated register.
    set_id(OP_LW, 2, 0, 0, C_LW); step();
    set_id(OP_RTYPE, 0, 0, 7, C_ADD); #1;
    check("lw0_no_stall", 64'(pc_write), 64'd1);
    step();
    set_id(OP_LW, 2, 8, 0, C_LW); step();
    set_id(OP_RTYPE, 9, 9, 7, C_ADD); #1;
    check("lw8_r9_no_stall", 64'(pc_write), 64'd1);
    step();

    // Flush wins over load-use.
    set_id(OP_LW, 2, 8, 0, C_LW); step();
    set_id(OP_RTYPE, 8, 10, 9, C_ADD); flush = 1'b1; #1;
    check("flush_pc_write", 64'(pc_write), 64'd1);
    step();
    flush = 1'b0;
    check("flush_ctrl", 64'(ID_EX_ctrl), 64'd0);
    check("flush_cnt", 64'(stall_cnt), 64'd1);

    // Hold three cycles over a pending load-use, then release into a single stall.
    set_id(OP_LW, 2, 8, 0, C_LW); step();
    set_id(OP_RTYPE, 8, 10, 9, C_ADD); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_pc_write", 64'(pc_write), 64'd0);
      step();
      check("hold_rt", 64'(ID_EX_rt), 64'd8);
      check("hold_ctrl", 64'(ID_EX_ctrl), 64'(C_LW));
      check("hold_cnt", 64'(stall_cnt), 64'd1);
    end
    hold = 1'b0; #1;
    check("rel_pc_write", 64'(pc_write), 64'd0);
    step();
    check("rel_cnt", 64'(stall_cnt), 64'd2);
    #1;
    check("rel_resume", 64'(pc_write), 64'd1);
    step();

    // WB bypass, and $0 never bypasses.
    set_id(OP_RTYPE, 5, 6, 7, C_ADD);
    rf_rdata1 = 0; wb_reg_write = 1'b1; wb_dst = 5; wb_data = 32'hDEADBEEF;
    step();
    check("byp_rs_data", 64'(ID_EX_rs_data), 64'hDEADBEEF);
    set_id(OP_RTYPE, 0, 6, 7, C_ADD);
    rf_rdata1 = 0; wb_dst = 0;
    step();
    check("byp_zero", 64'(ID_EX_rs_data), 64'd0);
    wb_reg_write = 1'b0;

    // Drive the counter to saturation and beyond.
    for (int i = 0; i < 16; i++) begin
      set_id(OP_LW, 2, 8, 0, C_LW); step();
      set_id(OP_RTYPE, 8, 10, 9, C_ADD); step();
    end
    check("sat_cnt", 64'(stall_cnt), 64'hF);

    // Randomized traffic with small register ranges so hazards and bypasses are frequent.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      hold  = ($urandom_range(0, 99) < 12);
      flush = ($urandom_range(0, 99) < 10);
      IF_ID_opcode = 6'($urandom); IF_ID_funct = 6'($urandom);
      IF_ID_rs = 5'($urandom_range(0, 3)); IF_ID_rt = 5'($urandom_range(0, 3));
      IF_ID_rd = 5'($urandom); IF_ID_shamt = 5'($urandom);
      id_imm = $urandom; id_pc4 = $urandom; rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      id_ctrl = 10'($urandom);
      wb_reg_write = 1'($urandom); wb_dst = 5'($urandom_range(0, 3)); wb_data = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
